// File: rtl/seg7_readback_decoder.sv
// rtl/seg7_readback_decoder.sv - seven-segment readback: settle, decode one digit per clock, hold for handshake
module seg7_readback_decoder #(
  parameter int NUM_DIGITS     = 6,
  parameter int STABLE_CYCLES  = 4,
  parameter int SETTLE_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic                    start,
  input  logic                    ready,
  output logic                    busy,
  output logic                    valid,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   invalid_mask,
  output logic                    timeout
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(SETTLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SCAN   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [8*NUM_DIGITS-1:0] r_snap;
  logic [STB_W-1:0]        r_stb;
  logic [TMO_W-1:0]        r_tmo;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_invalid;
  logic                    r_timeout;

  logic [7:0]       w_seg;
  logic [5:0]       w_dec;
  logic [STB_W-1:0] w_stb_next;
  logic [TMO_W-1:0] w_tmo_next;
  logic             w_same;
  logic             w_last;

  // Segment pattern (bits6..0, active-low) to {blank, invalid, nibble}.
  function automatic logic [5:0] decode_seg(input logic [6:0] pat);
    logic [5:0] res;
    case (pat)
      7'h40:   res = 6'b00_0000;
      7'h79:   res = 6'b00_0001;
      7'h24:   res = 6'b00_0010;
      7'h30:   res = 6'b00_0011;
      7'h19:   res = 6'b00_0100;
      7'h12:   res = 6'b00_0101;
      7'h02:   res = 6'b00_0110;
      7'h78:   res = 6'b00_0111;
      7'h00:   res = 6'b00_1000;
      7'h10:   res = 6'b00_1001;
      7'h08:   res = 6'b00_1010;
      7'h03:   res = 6'b00_1011;
      7'h46:   res = 6'b00_1100;
      7'h21:   res = 6'b00_1101;
      7'h06:   res = 6'b00_1110;
      7'h0E:   res = 6'b00_1111;
      7'h7F:   res = 6'b10_0000;
      default: res = 6'b01_0000;
    endcase
    return res;
  endfunction

  // Snapshot digit under the scan index and its decoded form.
  assign w_seg = r_snap[{r_idx, 3'b000} +: 8];
  assign w_dec = decode_seg(w_seg[6:0]);

  // Saturating next values for the settle counters.
  assign w_stb_next = (r_stb == STB_W'(STABLE_CYCLES))  ? r_stb : r_stb + 1'b1;
  assign w_tmo_next = (r_tmo == TMO_W'(SETTLE_TIMEOUT)) ? r_tmo : r_tmo + 1'b1;
  assign w_same     = (seg_in == r_snap);
  assign w_last     = (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Control FSM plus snapshot, counters and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_snap    <= '0;
      r_stb     <= '0;
      r_tmo     <= '0;
      r_idx     <= '0;
      r_value   <= '0;
      r_dp      <= '0;
      r_blank   <= '0;
      r_invalid <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snap  <= seg_in;
            r_stb   <= '0;
            r_tmo   <= '0;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_tmo <= w_tmo_next;
          if (w_same) begin
            r_stb <= w_stb_next;
          end else begin
            r_snap <= seg_in;
            r_stb  <= '0;
          end
          // Settling beats timing out when both happen on the same cycle.
          if (w_same && (w_stb_next == STB_W'(STABLE_CYCLES))) begin
            r_idx   <= '0;
            r_state <= S_SCAN;
          end else if (w_tmo_next == TMO_W'(SETTLE_TIMEOUT)) begin
            r_value   <= '0;
            r_dp      <= '0;
            r_blank   <= '0;
            r_invalid <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_HOLD;
          end
        end
        S_SCAN: begin
          r_value[{r_idx, 2'b00} +: 4] <= w_dec[3:0];
          r_dp[r_idx]                  <= ~w_seg[7];
          r_blank[r_idx]               <= w_dec[5];
          r_invalid[r_idx]             <= w_dec[4];
          if (w_last) begin
            r_timeout <= 1'b0;
            r_state   <= S_HOLD;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_HOLD: begin
          if (ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign valid        = (r_state == S_HOLD);
  assign value_out    = r_value;
  assign dp_out       = r_dp;
  assign blank_mask   = r_blank;
  assign invalid_mask = r_invalid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// tb/tb_seg7_readback_decoder.sv - randomized self-checking bench for seg7_readback_decoder
module tb_seg7_readback_decoder;

  localparam int ND  = 6;
  localparam int STB = 4;
  localparam int TMO = 64;

  logic            clk;
  logic            reset;
  logic [8*ND-1:0] seg_in;
  logic            start;
  logic            ready;
  logic            busy;
  logic            valid;
  logic [4*ND-1:0] value_out;
  logic [ND-1:0]   dp_out;
  logic [ND-1:0]   blank_mask;
  logic [ND-1:0]   invalid_mask;
  logic            timeout;

  int n_checks;
  int n_fail;

  seg7_readback_decoder #(
    .NUM_DIGITS(ND), .STABLE_CYCLES(STB), .SETTLE_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .start(start), .ready(ready),
    .busy(busy), .valid(valid), .value_out(value_out), .dp_out(dp_out),
    .blank_mask(blank_mask), .invalid_mask(invalid_mask), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment pattern shown for each hex digit (bits6..0, active-low).
  logic [6:0] seg_tbl [16];
  initial begin
    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: invert the display table digit by digit.
  task automatic model(input logic [8*ND-1:0] s, output logic [4*ND-1:0] v,
                       output logic [ND-1:0] dp, output logic [ND-1:0] bl,
                       output logic [ND-1:0] inv);
    v = '0; dp = '0; bl = '0; inv = '0;
    for (int k = 0; k < ND; k++) begin
      logic [7:0] d;
      bit hit;
      d = s[8*k +: 8];
      hit = 0;
      dp[k] = (d[7] == 1'b0);
      for (int j = 0; j < 16; j++) begin
        if (!hit && d[6:0] == seg_tbl[j]) begin
          v[4*k +: 4] = 4'(j);
          hit = 1;
        end
      end
      if (!hit) begin
        if (d[6:0] == 7'h7F) bl[k] = 1'b1;
        else                 inv[k] = 1'b1;
      end
    end
  endtask

  // mode 0: steady input, 1: HEX0 toggles every cycle, 2: HEX0 becomes F9 after E1
  task automatic start_and_wait(input int mode, output int cycles);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    cycles = 0;
    while (!valid && cycles < 300) begin
      if (mode == 1) seg_in[7:0] = seg_in[7:0] ^ 8'h39;
      if (mode == 2 && cycles == 1) seg_in[7:0] = 8'hF9;
      @(posedge clk); cycles++;
      @(negedge clk);
    end
    check("valid_reached", {63'd0, valid}, 64'd1);
  endtask

  task automatic handshake();
    logic [4*ND-1:0] v;
    v = value_out;
    @(negedge clk); ready = 1'b1;
    @(posedge clk);
    @(negedge clk); ready = 1'b0;
    check("hs_valid_low", {63'd0, valid}, 64'd0);
    check("hs_busy_low", {63'd0, busy}, 64'd0);
    check("hs_value_held", {40'd0, value_out}, {40'd0, v});
  endtask

  int cyc;
  logic [4*ND-1:0] ev;
  logic [ND-1:0]   edp, ebl, einv;
  logic [4*ND-1:0] held;

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; ready = 1'b0; seg_in = '1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_value", {40'd0, value_out}, 64'd0);
    check("rst_masks", {40'd0, dp_out, blank_mask, invalid_mask, 6'd0}, 64'd0);
    check("rst_timeout", {63'd0, timeout}, 64'd0);

    // Digits 1..6 on HEX5..HEX0.
    seg_in = 48'hF9A4B0999282;
    start_and_wait(0, cyc);
    check("dir_latency", 64'(cyc), 64'(STB + ND));
    check("dir_value", {40'd0, value_out}, 64'h123456);
    check("dir_dp", {58'd0, dp_out}, 64'd0);
    check("dir_blank", {58'd0, blank_mask}, 64'd0);
    check("dir_invalid", {58'd0, invalid_mask}, 64'd0);
    check("dir_timeout", {63'd0, timeout}, 64'd0);
    handshake();

    // Blank, unknown pattern, lit dp.
    seg_in = 48'hC0C0C040AAFF;
    start_and_wait(0, cyc);
    check("mix_value", {40'd0, value_out}, 64'd0);
    check("mix_blank", {58'd0, blank_mask}, 64'b000001);
    check("mix_invalid", {58'd0, invalid_mask}, 64'b000010);
    check("mix_dp", {58'd0, dp_out}, 64'b000100);
    handshake();

    // Input changes once during settle.
    seg_in = 48'hF9A4B09992C0;
    start_and_wait(2, cyc);
    check("unst_latency", 64'(cyc), 64'(STB + ND + 2));
    check("unst_value", {40'd0, value_out}, 64'h123451);
    handshake();

    // Never settles.
    seg_in = 48'hF9A4B09992C0;
    start_and_wait(1, cyc);
    check("tmo_latency", 64'(cyc), 64'(TMO));
    check("tmo_flag", {63'd0, timeout}, 64'd1);
    check("tmo_value", {40'd0, value_out}, 64'd0);
    check("tmo_masks", {40'd0, dp_out, blank_mask, invalid_mask, 6'd0}, 64'd0);
    handshake();

    // Backpressure with ignored start pulses, then start+ready together.
    seg_in = 48'h82F9A4B09992;
    start_and_wait(0, cyc);
    held = value_out;
    check("bp_value", {40'd0, held}, 64'h612345);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", {63'd0, valid}, 64'd1);
      check("bp_hold", {40'd0, value_out}, {40'd0, held});
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; ready = 1'b0;
    check("bp_start_ignored", {63'd0, busy}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_still_idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of SCAN.
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mid_scan_busy", {63'd0, busy}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_value", {40'd0, value_out}, 64'd0);
    check("mid_rst_valid", {63'd0, valid}, 64'd0);
    #1 reset = 1'b0;

    // Randomized digits against the table model.
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < ND; k++) begin
        int r;
        logic [6:0] p;
        r = int'($urandom_range(0, 9));
        if (r == 0)      p = 7'h7F;
        else if (r == 1) p = 7'($urandom);
        else             p = seg_tbl[$urandom_range(0, 15)];
        seg_in[8*k +: 8] = {1'($urandom), p};
      end
      model(seg_in, ev, edp, ebl, einv);
      start_and_wait(0, cyc);
      check("rnd_latency", 64'(cyc), 64'(STB + ND));
      check("rnd_value", {40'd0, value_out}, {40'd0, ev});
      check("rnd_dp", {58'd0, dp_out}, {58'd0, edp});
      check("rnd_blank", {58'd0, blank_mask}, {58'd0, ebl});
      check("rnd_invalid", {58'd0, invalid_mask}, {58'd0, einv});
      check("rnd_timeout", {63'd0, timeout}, 64'd0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      handshake();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_readback_decoder.md
Name: seg7_readback_decoder

Overview:
- Reads back the six board seven-segment buses (HEX5..HEX0 patterns, 8 bits each, active-low) and recovers the hex digit each one shows.
- Waits for the segment patterns to be stable, then decodes one digit per clock and presents the assembled value to a consumer with a valid/ready handshake.
- Used as the inverse of the team's digit-to-segment encoding, for on-board self-check and loopback testing of display drivers.

Parameters:
- NUM_DIGITS, 6, number of seven-segment digits scanned.
- STABLE_CYCLES, 4, consecutive unchanged cycles required before decoding; must be at least 1.
- SETTLE_TIMEOUT, 64, maximum cycles spent in SETTLE before aborting with a timeout; must be greater than STABLE_CYCLES.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- seg_in  in  8*NUM_DIGITS  packed segment buses; digit k occupies [8k+7:8k], so HEX0 is bits [7:0]; bit7 is the decimal point, bits6..0 are segments g..a; 0 means lit.
- start  in  1  request one readback; sampled only in IDLE.
- ready  in  1  consumer accepts the result.
- busy  out  1  high whenever state is not IDLE.
- valid  out  1  result is available; high only in HOLD.
- value_out  out  4*NUM_DIGITS  decoded nibbles; nibble k comes from digit k.
- dp_out  out  NUM_DIGITS  bit k = 1 when the decimal point of digit k is lit.
- blank_mask  out  NUM_DIGITS  bit k = 1 when digit k has all segments off (bits6..0 = 7F).
- invalid_mask  out  NUM_DIGITS  bit k = 1 when digit k shows a pattern not in the table and is not blank.
- timeout  out  1  the last result was aborted because the input did not settle.

Behaviour:
- Reset (asynchronous, any state): state becomes IDLE; every output and internal register becomes 0, including the snapshot, counters and digit index.
- Decode table, using bits6..0 in hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78,
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Blank (7F) gives nibble 0 and sets blank_mask[k].
  - Any other pattern gives nibble 0 and sets invalid_mask[k].
  - Bit7 is decoded only into dp_out[k] and does not affect the table lookup.
- FSM states: IDLE, SETTLE, SCAN, HOLD.
- IDLE:
  - If start=1, capture seg_in into the snapshot, clear the stable counter and timeout counter, and go to SETTLE.
  - Otherwise stay.
- SETTLE, evaluated each cycle:
  - The timeout counter increments every cycle.
  - If seg_in equals the snapshot, the stable counter increments. Otherwise the snapshot is reloaded from seg_in and the stable counter is cleared.
  - When the stable counter reaches STABLE_CYCLES, go to SCAN with the digit index at 0.
  - Else, when the timeout counter reaches SETTLE_TIMEOUT: clear value_out, dp_out, blank_mask and invalid_mask; set timeout=1; go to HOLD.
  - If both conditions are true in the same cycle, the stable condition wins.
- SCAN:
  - Each cycle, decode the snapshot digit at the current index and write its nibble, dp, blank and invalid bits. Then increment the index.
  - Decoding uses the snapshot, not the live seg_in, so input changes during SCAN are ignored.
  - After index NUM_DIGITS-1, set timeout=0 and go to HOLD.
- HOLD:
  - valid=1.
  - The result is transferred on the cycle with valid=1 and ready=1; go to IDLE, and valid falls on that edge.
  - Result outputs hold their values after the handshake until the next SCAN or timeout overwrites them.
- Latency with stable input and ready=1:
  - start is sampled at edge E0; valid rises after edge E(STABLE_CYCLES+NUM_DIGITS), which is edge 10 with the defaults.
  - The earliest next start is the cycle after the handshake edge.
- Boundary cases:
  - start while busy is ignored; there is no queuing.
  - start and ready together in HOLD: the handshake completes and start is ignored.
  - ready outside HOLD has no effect.
  - The timeout counter width must hold SETTLE_TIMEOUT without wrapping.
  - The stable counter saturates and does not wrap.
  - Reset asserted mid-SCAN or mid-HOLD discards the partial result immediately.

Test Plan:
- Reset check: assert reset asynchronously between clock edges -> all outputs read 0 at once; hold state is IDLE (busy=0).
- Decode all digits: seg_in HEX5..HEX0 = F9,A4,B0,99,92,82 held constant, start pulse at E0, ready=1 -> valid rises after E10 with value_out=24'h123456, dp_out=0, blank_mask=0, invalid_mask=0, timeout=0; valid falls after E11.
- Mixed patterns: HEX0=FF, HEX1=AA, HEX2=40 (dp lit, 0), HEX3..HEX5=C0 -> nibbles 0; blank_mask=6'b000001, invalid_mask=6'b000010, dp_out=6'b000100.
- Unstable input: toggle HEX0 between C0 and F9 at E2, then hold it stable -> valid delayed to 2 cycles beyond the undisturbed case, decoded nibble 0 = 1.
- Timeout: HEX0 toggles every cycle -> after SETTLE_TIMEOUT=64 cycles valid=1, timeout=1, all masks and values 0.
- Backpressure and reset: hold ready=0 for 5 cycles in HOLD -> valid and value stay constant while start pulses are ignored. Then assert reset during SCAN on a second run -> busy=0 and value_out=0 immediately.
